// File: rtl/weight_fetch_pkg.sv
// Shared types and helpers for the weight ROM fetch sequencer and its byte packer.
package weight_fetch_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A single-lane build still needs a 1-bit lane index.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/weight_fetch_byte_packer.sv
// Packs returning ROM bytes into LANES-wide beats and holds them on a valid/ready output.
module weight_fetch_byte_packer
  import weight_fetch_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    byte_vld_i,
  input  logic [BYTE_W-1:0]       byte_i,
  input  logic                    byte_last_i,
  input  logic                    pend_i,
  output logic                    credit_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*BYTE_W-1:0] out_data_o,
  output logic                    out_last_o
);

  localparam int LIDX_W = lane_idx_w(LANES);
  localparam int FILL_W = LIDX_W + 1;
  localparam int CNT_W  = LIDX_W + 2;

  logic [LANES-1:0][BYTE_W-1:0] asm_q, asm_d, word;
  logic [FILL_W-1:0]            fill_q, fill_d;
  logic                         asm_last_q, asm_last_d;
  logic [LANES*BYTE_W-1:0]      out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic                         out_free, stalled, complete, move;
  logic [CNT_W-1:0]             committed;

  always_comb begin
    out_free = !out_valid_q || out_ready_i;
    stalled  = (fill_q == FILL_W'(LANES));
    complete = byte_vld_i && (fill_q == FILL_W'(LANES - 1));
    move     = out_free && (stalled || complete);

    word = asm_q;
    if (byte_vld_i) word[fill_q[LIDX_W-1:0]] = byte_i;

    asm_d       = word;
    fill_d      = fill_q;
    asm_last_d  = complete ? byte_last_i : asm_last_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_ready_i;

    if (move) begin
      out_data_d  = word;
      out_last_d  = stalled ? asm_last_q : byte_last_i;
      out_valid_d = 1'b1;
      fill_d      = '0;
    end else if (byte_vld_i) begin
      fill_d = fill_q + FILL_W'(1);
    end

    // A read decided now lands two cycles later; assume the consumer stalls from next cycle on.
    committed = CNT_W'(fill_q) + CNT_W'(byte_vld_i) + CNT_W'(pend_i);
    credit_o  = (committed < CNT_W'(LANES)) ||
                (out_free && (committed < CNT_W'(2 * LANES)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= '0;
      fill_q      <= '0;
      asm_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      fill_q      <= fill_d;
      asm_last_q  <= asm_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule

// File: rtl/weight_fetch.sv
// Walks a contiguous weight ROM range and streams the bytes out as packed LANES-wide beats.
// state    | meaning
// ST_IDLE  | waiting for start; zero-length commands only pulse done
// ST_FETCH | issuing one ROM read per cycle while the packer has credit
// ST_DRAIN | all reads issued; waiting for the final beat handshake
module weight_fetch
  import weight_fetch_pkg::*;
#(
  parameter int  DEPTH  = 1024,
  parameter int  LANES  = 4,
  parameter int  LEN_W  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LEN_W-1:0]        num_beats,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [BYTE_W-1:0]       rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*BYTE_W-1:0] out_data,
  output logic                    out_last
);

  localparam int LIDX_W = lane_idx_w(LANES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, nxt_q, nxt_d, iss_addr;
  logic [LEN_W-1:0]    beats_q, beats_d, iss_beats;
  logic [LIDX_W-1:0]   lane_q, lane_d, iss_lane;
  logic                rd_q, rd_d, rd_last_q, rd_last_d;
  logic                vld_q, vld_last_q;
  logic                zdone_q, zdone_d;
  logic                issue, last_byte, fin, credit;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    nxt_d     = nxt_q;
    beats_d   = beats_q;
    lane_d    = lane_q;
    rd_d      = 1'b0;
    rd_last_d = 1'b0;
    zdone_d   = 1'b0;
    issue     = 1'b0;
    fin       = 1'b0;
    iss_addr  = nxt_q;
    iss_beats = beats_q;
    iss_lane  = lane_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_beats == '0) begin
            zdone_d = 1'b1;
          end else begin
            issue     = 1'b1;
            iss_addr  = base_addr;
            iss_beats = num_beats;
            iss_lane  = LIDX_W'(LANES - 1);
          end
        end
      end
      ST_FETCH: issue = credit;
      ST_DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Beat and lane counters run down; the final byte is the terminal count of both.
    last_byte = (iss_beats == LEN_W'(1)) && (iss_lane == '0);
    if (issue) begin
      addr_d    = iss_addr;
      nxt_d     = (iss_addr == ADDR_W'(DEPTH - 1)) ? '0 : iss_addr + ADDR_W'(1);
      rd_d      = 1'b1;
      rd_last_d = last_byte;
      lane_d    = (iss_lane == '0) ? LIDX_W'(LANES - 1) : iss_lane - LIDX_W'(1);
      beats_d   = (iss_lane == '0) ? iss_beats - LEN_W'(1) : iss_beats;
      state_d   = last_byte ? ST_DRAIN : ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      nxt_q      <= '0;
      beats_q    <= '0;
      lane_q     <= '0;
      rd_q       <= 1'b0;
      rd_last_q  <= 1'b0;
      vld_q      <= 1'b0;
      vld_last_q <= 1'b0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      nxt_q      <= nxt_d;
      beats_q    <= beats_d;
      lane_q     <= lane_d;
      rd_q       <= rd_d;
      rd_last_q  <= rd_last_d;
      vld_q      <= rd_q;
      vld_last_q <= rd_last_q;
      zdone_q    <= zdone_d;
    end
  end

  weight_fetch_byte_packer #(.LANES(LANES)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .byte_vld_i  (vld_q),
    .byte_i      (rom_data),
    .byte_last_i (vld_last_q),
    .pend_i      (rd_q),
    .credit_o    (credit),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = zdone_q | fin;
  assign rom_addr = addr_q;

endmodule
